// File: rtl/btn_pkg.sv
// Shared types and helpers for the btn_bank button front end.
package btn_pkg;

    typedef enum logic [1:0] {
        BTN_UP   = 2'd0,
        BTN_DOWN = 2'd1,
        BTN_HELD = 2'd2
    } btn_state_t;

    localparam int PRESS_COUNT_W = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce filter, press/long FSM, optional
// auto-repeat (built only when BTN_AUTO_REPEAT_EN is defined).
//
// state    | meaning
// BTN_UP   | debounced level is released
// BTN_DOWN | pressed, hold counter running toward the long-press threshold
// BTN_HELD | long press reached; auto-repeat runs here when built
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 2,
    parameter int LONG_PRESS_CYCLES = 8,
    parameter int REPEAT_CYCLES     = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic stable_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int CW = clog2_min1(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

    if (SYNC_STAGES < 2)       begin : g_bad_sync  $error("SYNC_STAGES must be >= 2");       end
    if (DEBOUNCE_CYCLES < 1)   begin : g_bad_deb   $error("DEBOUNCE_CYCLES must be >= 1");   end
    if (LONG_PRESS_CYCLES < 2) begin : g_bad_long  $error("LONG_PRESS_CYCLES must be >= 2"); end
    if (REPEAT_CYCLES < 1)     begin : g_bad_rep   $error("REPEAT_CYCLES must be >= 1");     end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [HW-1:0]          hold_q, hold_d;
    btn_state_t             state_q, state_d;
    logic                   stable_q, stable_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;
    logic                   s;
    logic                   commit;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            state_q   <= BTN_UP;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        commit    = 1'b0;
        if (s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
            stable_d  = s;
            cnt_d     = '0;
            commit    = 1'b1;
            press_d   = s;
            release_d = ~s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A release commit always wins over a long-press threshold on the same cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        long_d  = 1'b0;
        if (commit && s) begin
            state_d = BTN_DOWN;
            hold_d  = '0;
        end else if (commit) begin
            state_d = BTN_UP;
        end else begin
            case (state_q)
                BTN_DOWN: begin
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HW'(1);
                        if (hold_d == HOLD_MAX) begin
                            state_d = BTN_HELD;
                            long_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RW = clog2_min1(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES);

    logic [RW-1:0] rep_q, rep_d;
    logic          repeat_q, repeat_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            rep_q    <= rep_d;
            repeat_q <= repeat_d;
        end
    end

    always_comb begin
        rep_d    = '0;
        repeat_d = 1'b0;
        if (state_q == BTN_HELD && !commit) begin
            rep_d = rep_q + RW'(1);
            if (rep_d == REP_LAST) begin
                repeat_d = 1'b1;
                rep_d    = '0;
            end
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

    assign stable_o  = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/btn_bank.sv
// Multi-channel button bank: NUM_BTNS btn_channel instances plus a bank-wide
// press counter. Auto-repeat is built only with BTN_AUTO_REPEAT_EN defined.
module btn_bank
    import btn_pkg::*;
#(
    parameter int NUM_BTNS          = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 2,
    parameter int LONG_PRESS_CYCLES = 8,
    parameter int REPEAT_CYCLES     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_BTNS-1:0]      btn_i,
    output logic [NUM_BTNS-1:0]      stable_o,
    output logic [NUM_BTNS-1:0]      press_pulse_o,
    output logic [NUM_BTNS-1:0]      release_pulse_o,
    output logic [NUM_BTNS-1:0]      long_pulse_o,
    output logic [NUM_BTNS-1:0]      repeat_pulse_o,
    output logic [PRESS_COUNT_W-1:0] press_count_o
);

    if (NUM_BTNS < 1) begin : g_bad_num $error("NUM_BTNS must be >= 1"); end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES      (SYNC_STAGES),
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .REPEAT_CYCLES    (REPEAT_CYCLES)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .btn_i    (btn_i[i]),
            .stable_o (stable_o[i]),
            .press_o  (press_pulse_o[i]),
            .release_o(release_pulse_o[i]),
            .long_o   (long_pulse_o[i]),
            .repeat_o (repeat_pulse_o[i])
        );
    end

    logic [PRESS_COUNT_W-1:0] count_q, count_d;
    logic [PRESS_COUNT_W-1:0] pop;

    // Counter wraps naturally at 2**PRESS_COUNT_W.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            pop = pop + PRESS_COUNT_W'(press_pulse_o[i]);
        end
        count_d = count_q + pop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign press_count_o = count_q;

endmodule

// File: tb/tb_btn_bank.sv
// Directed self-checking bench for btn_bank at default parameters.
module tb_btn_bank;
    import btn_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [3:0]               btn = '0;
    logic [3:0]               stable, press_p, release_p, long_p, repeat_p;
    logic [PRESS_COUNT_W-1:0] press_count;

    int n_chk  = 0;
    int n_pass = 0;

    btn_bank dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .btn_i          (btn),
        .stable_o       (stable),
        .press_pulse_o  (press_p),
        .release_pulse_o(release_p),
        .long_pulse_o   (long_p),
        .repeat_pulse_o (repeat_p),
        .press_count_o  (press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic exp_rep(input int k, input int long_k);
`ifdef BTN_AUTO_REPEAT_EN
        return (k > long_k) && (((k - long_k) % 4) == 0);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        // 1: reset
        cyc(5);
        chk("rst_stable", 32'(stable), 0);
        chk("rst_press", 32'(press_p), 0);
        chk("rst_count", 32'(press_count), 0);
        rst_n = 1'b1;
        cyc(3);
        chk("idle_outputs", 32'({stable, press_p, release_p, long_p, repeat_p}), 0);
        chk("idle_count", 32'(press_count), 0);

        // 2/6: hold ch0 for 30 cycles
        btn[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cyc(1);
            chk("hold_press0", 32'(press_p[0]), 32'(k == 4));
            chk("hold_long0", 32'(long_p[0]), 32'(k == 12));
            chk("hold_repeat0", 32'(repeat_p[0]), 32'(exp_rep(k, 12)));
            if (k == 3) chk("stable0_pre", 32'(stable[0]), 0);
            if (k == 4) chk("stable0_commit", 32'(stable[0]), 1);
            if (k == 5) chk("count_after_press", 32'(press_count), 1);
        end
        btn[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk("rel_pulse0", 32'(release_p[0]), 32'(k == 4));
            chk("rel_repeat0", 32'(repeat_p[0]), 0);
        end
        chk("stable0_released", 32'(stable[0]), 0);
        cyc(3);

        // 3: one-cycle glitch on ch1
        btn[1] = 1'b1;
        cyc(1);
        btn[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk("glitch_stable1", 32'(stable[1]), 0);
            chk("glitch_press1", 32'(press_p[1]), 0);
        end
        chk("glitch_count", 32'(press_count), 1);

        // 4: simultaneous press, then wrap the counter
        btn = 4'hF;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            if (k <= 4) chk("all_press", 32'(press_p), (k == 4) ? 32'hF : 32'h0);
        end
        chk("all_count", 32'(press_count), 5);
        btn = 4'h0;
        cyc(8);
        chk("all_released", 32'(stable), 0);
        for (int p = 0; p < 250; p++) begin
            btn[0] = 1'b1;
            cyc(5);
            btn[0] = 1'b0;
            cyc(5);
        end
        chk("count_255", 32'(press_count), 255);
        btn[0] = 1'b1;
        cyc(5);
        btn[0] = 1'b0;
        cyc(5);
        chk("count_wrap0", 32'(press_count), 0);

        // 5a: short press on ch2
        btn[2] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (k == 7) btn[2] = 1'b0;
            chk("short_press2", 32'(press_p[2]), 32'(k == 4));
            chk("short_release2", 32'(release_p[2]), 32'(k == 11));
            chk("short_long2", 32'(long_p[2]), 0);
        end
        chk("short_count", 32'(press_count), 1);

        // 5b: reset in the middle of a hold on ch0
        btn[0] = 1'b1;
        cyc(6);
        chk("pre_rst_stable0", 32'(stable[0]), 1);
        chk("pre_rst_count", 32'(press_count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({stable, press_p, release_p, long_p, repeat_p}), 0);
        chk("async_rst_count", 32'(press_count), 0);
        cyc(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc(1);
            chk("repress0", 32'(press_p[0]), 32'(k == 4));
            chk("repress_long0", 32'(long_p[0]), 32'(k == 12));
        end
        chk("repress_count", 32'(press_count), 1);
        btn[0] = 1'b0;
        cyc(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
